// File: rtl/cic_dec_shifter_seq.sv
// Gain normaliser behind the 4-stage CIC decimator.
// A small FSM turns the decimation rate into the CIC bit growth ceil(4*log2(R)).
// Each strobed wide sample is rounded half-up, shifted right by that growth,
// saturated to BW bits and registered (one clock of latency).
module cic_dec_shifter_seq #(
  parameter int BW         = 16,
  parameter int MAXBITGAIN = 28
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [7:0]                 rate,
  input  logic                       strobe_in,
  input  logic [BW+MAXBITGAIN-1:0]   signal_in,
  output logic                       strobe_out,
  output logic [BW-1:0]              signal_out,
  output logic                       sat_out,
  output logic [4:0]                 shift,
  output logic                       busy
);

  localparam int IW = BW + MAXBITGAIN;  // input width
  localparam int XW = IW + 1;           // one guard bit for the rounding add

  localparam logic signed [XW-1:0] LP_MAX = XW'((2 ** (BW - 1)) - 1);
  localparam logic signed [XW-1:0] LP_MIN = ~LP_MAX;

  typedef enum logic [2:0] {S_IDLE, S_SQ1, S_SQ2, S_ENC, S_LOAD} state_t;

  state_t         r_state;
  logic [7:0]     r_rate_q;
  logic [35:0]    r_p;
  logic [5:0]     r_g;
  logic [4:0]     r_shift;
  logic           r_busy;
  logic           r_strobe_out;
  logic [BW-1:0]  r_signal_out;
  logic           r_sat_out;

  logic [8:0]     w_r;
  logic [17:0]    w_sq;
  logic [35:0]    w_p4;
  logic [35:0]    w_pm1;
  logic [5:0]     w_g;
  logic [4:0]     w_g_clamp;

  logic signed [XW-1:0] w_x_ext;
  logic signed [XW-1:0] w_round;
  logic signed [XW-1:0] w_x;
  logic signed [XW-1:0] w_y;
  logic [BW-1:0]        w_out;
  logic                 w_sat;
  logic                 w_take;

  // R = rate_q + 1 squared twice gives R^4 (up to 2^32 for R = 256)
  assign w_r   = {1'b0, r_rate_q} + 9'd1;
  assign w_sq  = {9'd0, w_r} * {9'd0, w_r};
  assign w_p4  = {18'd0, r_p[17:0]} * {18'd0, r_p[17:0]};
  assign w_pm1 = r_p - 36'd1;

  // Bit length of R^4 - 1: smallest g with 2^g >= R^4
  always_comb begin
    w_g = '0;
    for (int i = 0; i < 36; i++) begin
      if (w_pm1[i]) w_g = 6'(i + 1);
    end
  end

  assign w_g_clamp = (r_g > 6'(MAXBITGAIN)) ? 5'(MAXBITGAIN) : r_g[4:0];

  // Shift FSM: any rate change restarts the computation from SQ1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_SQ1;
      r_rate_q <= '0;
      r_p      <= '0;
      r_g      <= '0;
      r_shift  <= 5'(MAXBITGAIN);
      r_busy   <= 1'b1;
    end else if (rate != r_rate_q) begin
      r_rate_q <= rate;
      r_state  <= S_SQ1;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        S_SQ1: begin
          r_p     <= {18'd0, w_sq};
          r_state <= S_SQ2;
        end
        S_SQ2: begin
          r_p     <= w_p4;
          r_state <= S_ENC;
        end
        S_ENC: begin
          r_g     <= w_g;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift <= w_g_clamp;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Round half-up, arithmetic shift, then clamp to the signed BW-bit range
  assign w_x_ext = {signal_in[IW-1], signal_in};
  assign w_round = (r_shift != 5'd0) ? ({{(XW-1){1'b0}}, 1'b1} << (r_shift - 5'd1)) : '0;
  assign w_x     = w_x_ext + w_round;
  assign w_y     = w_x >>> r_shift;
  assign w_take  = strobe_in & ~r_busy;

  always_comb begin
    w_out = w_y[BW-1:0];
    w_sat = 1'b0;
    if (w_y > LP_MAX) begin
      w_out = LP_MAX[BW-1:0];
      w_sat = 1'b1;
    end else if (w_y < LP_MIN) begin
      w_out = LP_MIN[BW-1:0];
      w_sat = 1'b1;
    end
  end

  // Output register: sample held between strobes, sat and strobe are pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_out <= 1'b0;
      r_signal_out <= '0;
      r_sat_out    <= 1'b0;
    end else begin
      r_strobe_out <= w_take;
      if (w_take) begin
        r_signal_out <= w_out;
        r_sat_out    <= w_sat;
      end else begin
        r_sat_out    <= 1'b0;
      end
    end
  end

  assign strobe_out = r_strobe_out;
  assign signal_out = r_signal_out;
  assign sat_out    = r_sat_out;
  assign shift      = r_shift;
  assign busy       = r_busy;

endmodule

// File: tb/tb_cic_dec_shifter_seq.sv
// Directed bench for cic_dec_shifter_seq: vector table plus multi-cycle sequences.
module tb_cic_dec_shifter_seq;

  logic               clock;
  logic               reset_n;
  logic [7:0]         rate;
  logic               strobe_in;
  logic signed [43:0] signal_in;
  logic               strobe_out;
  logic [15:0]        signal_out;
  logic               sat_out;
  logic [4:0]         shift;
  logic               busy;

  int checks = 0;
  int errors = 0;

  cic_dec_shifter_seq #(.BW(16), .MAXBITGAIN(28)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .signal_in  (signal_in),
    .strobe_out (strobe_out),
    .signal_out (signal_out),
    .sat_out    (sat_out),
    .shift      (shift),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]         rate;
    logic [4:0]         shift;
    logic signed [43:0] din;
    logic signed [15:0] dout;
    logic               sat;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Wait on negedges until busy falls, bounded by limit clocks
  task automatic wait_idle(input int limit, input string nm);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk(nm, longint'(busy), 0);
  endtask

  // Strobe one sample and check the registered result one clock later
  task automatic send(input logic signed [43:0] d, input logic signed [15:0] e,
                      input logic es, input string nm);
    signal_in = d;
    strobe_in = 1'b1;
    @(negedge clock);
    strobe_in = 1'b0;
    chk({nm, " strobe"}, longint'(strobe_out), 1);
    chk({nm, " out"}, longint'($signed(signal_out)), longint'(e));
    chk({nm, " sat"}, longint'(sat_out), longint'(es));
  endtask

  initial begin
    vecs[0]  = '{8'd3,   5'd8,  44'sd256000,          16'sd1000,   1'b0};
    vecs[1]  = '{8'd3,   5'd8,  44'sd384,             16'sd2,      1'b0};
    vecs[2]  = '{8'd3,   5'd8,  44'sd383,             16'sd1,      1'b0};
    vecs[3]  = '{8'd3,   5'd8,  -44'sd384,            -16'sd1,     1'b0};
    vecs[4]  = '{8'd3,   5'd8,  -44'sd385,            -16'sd2,     1'b0};
    vecs[5]  = '{8'd0,   5'd0,  44'sd40000,           16'sd32767,  1'b1};
    vecs[6]  = '{8'd0,   5'd0,  -44'sd40000,          -16'sd32768, 1'b1};
    vecs[7]  = '{8'd0,   5'd0,  -44'sd123,            -16'sd123,   1'b0};
    vecs[8]  = '{8'd4,   5'd10, 44'sd5632,            16'sd6,      1'b0};
    vecs[9]  = '{8'd7,   5'd12, 44'sd409600,          16'sd100,    1'b0};
    vecs[10] = '{8'd15,  5'd16, -44'sd196608,         -16'sd3,     1'b0};
    vecs[11] = '{8'd15,  5'd16, -44'sh800_0000_0000,  -16'sd32768, 1'b1};
    vecs[12] = '{8'd127, 5'd28, 44'sh7FF_FFFF_FFFF,   16'sd32767,  1'b1};
    vecs[13] = '{8'd127, 5'd28, -44'sh800_0000_0000,  -16'sd32768, 1'b0};
    vecs[14] = '{8'd127, 5'd28, 44'sh400_0000_0000,   16'sd16384,  1'b0};
    vecs[15] = '{8'd255, 5'd28, 44'sd1073741824,      16'sd4,      1'b0};

    reset_n   = 1'b1;
    rate      = 8'd3;
    strobe_in = 1'b0;
    signal_in = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset strobe_out", longint'(strobe_out), 0);
    chk("reset signal_out", longint'(signal_out), 0);
    chk("reset sat_out", longint'(sat_out), 0);
    chk("reset shift", longint'(shift), 28);
    chk("reset busy", longint'(busy), 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wait_idle(6, "startup busy low");
    chk("startup shift", longint'(shift), 8);

    // Table-driven vectors; a new rate waits for the recomputed shift
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rate != rate) begin
        rate = vecs[i].rate;
        @(negedge clock);
        chk($sformatf("rate %0d busy", vecs[i].rate), longint'(busy), 1);
        wait_idle(10, $sformatf("rate %0d settle", vecs[i].rate));
        chk($sformatf("rate %0d shift", vecs[i].rate), longint'(shift), longint'(vecs[i].shift));
      end
      send(vecs[i].din, vecs[i].dout, vecs[i].sat, $sformatf("vec%0d", i));
    end
    @(negedge clock);
    chk("idle strobe_out", longint'(strobe_out), 0);
    chk("idle holds out", longint'($signed(signal_out)), 4);

    // Back-to-back strobes at shift=8 produce outputs every clock
    rate = 8'd3;
    @(negedge clock);
    wait_idle(10, "b2b settle");
    strobe_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      signal_in = 44'sd256 * (k + 1);
      @(negedge clock);
      chk($sformatf("b2b%0d strobe", k), longint'(strobe_out), 1);
      chk($sformatf("b2b%0d out", k), longint'($signed(signal_out)), longint'(k + 1));
    end
    strobe_in = 1'b0;

    // Rate change on a strobe edge uses the old shift, then restart while in SQ2
    signal_in = 44'sd256000;
    strobe_in = 1'b1;
    rate = 8'd7;
    @(negedge clock);
    chk("rchg old-shift strobe", longint'(strobe_out), 1);
    chk("rchg old-shift out", longint'($signed(signal_out)), 1000);
    chk("rchg busy", longint'(busy), 1);
    @(negedge clock);
    rate = 8'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("restart busy c%0d", k), longint'(busy), 1);
      chk($sformatf("restart drop c%0d", k), longint'(strobe_out), 0);
    end
    @(negedge clock);
    chk("restart busy low", longint'(busy), 0);
    chk("restart shift", longint'(shift), 10);
    chk("restart drop last", longint'(strobe_out), 0);
    strobe_in = 1'b0;
    @(negedge clock);

    // Asynchronous reset while strobe_out is high
    signal_in = 44'sd5632;
    strobe_in = 1'b1;
    @(posedge clock);
    #1 strobe_in = 1'b0;
    chk("pre-reset strobe", longint'(strobe_out), 1);
    reset_n = 1'b0;
    #1;
    chk("async strobe_out", longint'(strobe_out), 0);
    chk("async signal_out", longint'(signal_out), 0);
    chk("async shift", longint'(shift), 28);
    chk("async busy", longint'(busy), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wait_idle(10, "post-reset settle");
    chk("post-reset shift", longint'(shift), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
